// File: rtl/kab_io_pkg.sv
// rtl/kab_io_pkg.sv - shared constants and types for the key event unit
// Contents:
//   KEV_* register word indices for the key event register window
//   key_vec_t  per-key bit vector, sized for the largest supported key count
//   kev_word   zero-extends a key vector onto the 32-bit register bus
package kab_io_pkg;

   localparam int KEV_MAX_KEYS = 8;

   localparam logic [1:0] KEV_STATE   = 2'd0;
   localparam logic [1:0] KEV_PENDING = 2'd1;
   localparam logic [1:0] KEV_ENABLE  = 2'd2;
   localparam logic [1:0] KEV_EDGECFG = 2'd3;

   // Key vectors are carried at the maximum width; bits above the
   // instantiated key count are held at zero so they read back as 0.
   typedef logic [KEV_MAX_KEYS-1:0] key_vec_t;

   function automatic logic [31:0] kev_word(input key_vec_t v);
      return {{(32-KEV_MAX_KEYS){1'b0}}, v};
   endfunction

endpackage

// File: rtl/key_event_unit_debouncer.sv
// rtl/key_event_unit_debouncer.sv - synchronizer and debounce counter for one key
// Ports:
//   IO_Clock  I/O domain clock
//   IO_Reset  asynchronous active-low reset
//   RawKey    raw key pin, asynchronous, low = pressed
//   Level     debounced level, 1 = pressed
//   Rise      one-cycle pulse, registered alongside a Level 0->1 change
//   Fall      one-cycle pulse, registered alongside a Level 1->0 change
module key_debouncer
   import kab_io_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = 250000,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic IO_Clock,
   input  logic IO_Reset,
   input  logic RawKey,
   output logic Level,
   output logic Rise,
   output logic Fall
);

   logic             sync1;
   logic             sync2;
   logic             sample;
   logic             differ;
   logic             expire;
   logic [CNT_W-1:0] cnt;

   // Synchronizer resets to the released (high) pin level so that coming
   // out of reset never looks like a press.
   assign sample = ~sync2;
   assign differ = sample ^ Level;
   // The D-th consecutive differing sample is the one that flips Level.
   assign expire = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge IO_Clock or negedge IO_Reset) begin
      if (!IO_Reset) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         cnt   <= '0;
         Level <= 1'b0;
         Rise  <= 1'b0;
         Fall  <= 1'b0;
      end else begin
         sync1 <= RawKey;
         sync2 <= sync1;
         Rise  <= expire & ~Level;
         Fall  <= expire & Level;
         if (!differ || expire) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (expire) begin
            Level <= ~Level;
         end
      end
   end

endmodule

// File: rtl/key_event_unit.sv
// rtl/key_event_unit.sv - debounced key events with pending/enable registers and EIC request
// Ports:
//   IO_Clock  I/O domain clock
//   IO_Reset  asynchronous active-low reset
//   Keys      raw key pins, low = pressed
//   RdEn      register read strobe; RdData loads on the following edge
//   WrEn      register write strobe
//   Address   register word index (STATE, PENDING, ENABLE, EDGE_CFG)
//   WrData    write data; bits above NUM_KEYS are ignored
//   RdData    registered read data
//   IntReq    level interrupt request to the EIC
//   IntAck    one-cycle acknowledge from the EIC
module key_event_unit
   import kab_io_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 250000
) (
   input  logic                IO_Clock,
   input  logic                IO_Reset,
   input  logic [NUM_KEYS-1:0] Keys,
   input  logic                RdEn,
   input  logic                WrEn,
   input  logic [1:0]          Address,
   input  logic [31:0]         WrData,
   output logic [31:0]         RdData,
   output logic                IntReq,
   input  logic                IntAck
);

   logic [NUM_KEYS-1:0] level;
   logic [NUM_KEYS-1:0] rise;
   logic [NUM_KEYS-1:0] fall;
   logic [NUM_KEYS-1:0] pending_q;
   logic [NUM_KEYS-1:0] enable_q;
   logic [NUM_KEYS-1:0] edge_cfg_q;
   logic [NUM_KEYS-1:0] event_v;
   logic [NUM_KEYS-1:0] w1c_mask;
   logic [NUM_KEYS-1:0] pending_n;
   logic [NUM_KEYS-1:0] enable_n;
   logic [NUM_KEYS-1:0] edge_cfg_n;
   logic                ack_q;
   logic                ack_n;
   logic                irq_n;
   logic                wr_pending;
   logic                wr_enable;
   logic                wr_edge_cfg;
   key_vec_t            rd_sel;
   logic                unused_wrdata;

   assign unused_wrdata = ^WrData[31:NUM_KEYS];

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
      key_debouncer #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debouncer (
         .IO_Clock (IO_Clock),
         .IO_Reset (IO_Reset),
         .RawKey   (Keys[i]),
         .Level    (level[i]),
         .Rise     (rise[i]),
         .Fall     (fall[i])
      );
   end

   assign wr_pending  = WrEn && (Address == KEV_PENDING);
   assign wr_enable   = WrEn && (Address == KEV_ENABLE);
   assign wr_edge_cfg = WrEn && (Address == KEV_EDGECFG);

   always_comb begin
      // EDGE_CFG bit 0 selects press events, 1 selects release events.
      event_v    = (rise & ~edge_cfg_q) | (fall & edge_cfg_q);
      w1c_mask   = wr_pending ? WrData[NUM_KEYS-1:0] : '0;
      // OR-ing the event after the clear lets a same-cycle event win.
      pending_n  = (pending_q & ~w1c_mask) | event_v;
      enable_n   = wr_enable   ? WrData[NUM_KEYS-1:0] : enable_q;
      edge_cfg_n = wr_edge_cfg ? WrData[NUM_KEYS-1:0] : edge_cfg_q;

      // A freshly raised pending bit or any software service of PENDING
      // re-arms the request; otherwise an acknowledge holds it off.
      ack_n = ack_q;
      if (((pending_n & ~pending_q) != '0) || wr_pending) begin
         ack_n = 1'b0;
      end else if (IntAck) begin
         ack_n = 1'b1;
      end
      irq_n = ((pending_n & enable_n) != '0) && !ack_n;
   end

   // Read mux uses current register values, so a read paired with a write
   // returns the pre-write contents.
   always_comb begin
      rd_sel = '0;
      case (Address)
         KEV_STATE:   rd_sel[NUM_KEYS-1:0] = level;
         KEV_PENDING: rd_sel[NUM_KEYS-1:0] = pending_q;
         KEV_ENABLE:  rd_sel[NUM_KEYS-1:0] = enable_q;
         KEV_EDGECFG: rd_sel[NUM_KEYS-1:0] = edge_cfg_q;
         default:     rd_sel = '0;
      endcase
   end

   always_ff @(posedge IO_Clock or negedge IO_Reset) begin
      if (!IO_Reset) begin
         pending_q  <= '0;
         enable_q   <= '0;
         edge_cfg_q <= '0;
         ack_q      <= 1'b0;
         IntReq     <= 1'b0;
         RdData     <= '0;
      end else begin
         pending_q  <= pending_n;
         enable_q   <= enable_n;
         edge_cfg_q <= edge_cfg_n;
         ack_q      <= ack_n;
         IntReq     <= irq_n;
         if (RdEn) begin
            RdData <= kev_word(rd_sel);
         end
      end
   end

endmodule
